// File: rtl/Purple_Jade_pkg.sv
// Purple_Jade_pkg: shared types and constants for the issue/execute slice.
//   WORD_SIZE_P          datapath width
//   issued_instruction_t instruction handed from the issue table to an FU
//   CDB_t                common data bus slot {valid, dest, result}
//   OP_MUL/OP_DIV/OP_REM opcodes served by muldiv_fu (FU index FU_MULDIV)
//   divfsm_e             iterative divider sequencing states
package Purple_Jade_pkg;

  localparam int unsigned WORD_SIZE_P = 16;
  localparam int unsigned OPCODE_W    = 4;
  localparam int unsigned TAG_W       = 4;
  localparam int unsigned CDB_DEST_W  = 6;

  localparam logic [OPCODE_W-1:0] OP_MUL = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_DIV = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_REM = 4'hA;

  localparam int unsigned FU_MULDIV = 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } divfsm_e;

  typedef struct packed {
    logic [OPCODE_W-1:0]    opcode;
    logic [TAG_W-1:0]       dest_id;
    logic [WORD_SIZE_P-1:0] source_1_data;
    logic [WORD_SIZE_P-1:0] source2_imm_data;
  } issued_instruction_t;

  typedef struct packed {
    logic                   valid;
    logic [CDB_DEST_W-1:0]  dest;
    logic [WORD_SIZE_P-1:0] result;
  } CDB_t;

endpackage

// File: rtl/muldiv_fu_iterative_divider.sv
// iterative_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk_i, reset_i (async, active-low)
//   start_i      accept a_i / b_i / dest_i / rem_sel_i (only honoured in IDLE)
//   flush_i      abandon any division, back to IDLE at the next edge
//   idle_o       FSM is IDLE (unit can take a new divide)
//   done_o       FSM is DONE; quotient_o / remainder_o / dest_o / rem_sel_o valid
// Division by zero falls out of the algorithm: quotient all ones, remainder A.
module iterative_divider
  import Purple_Jade_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   flush_i,
  input  logic [WORD_SIZE_P-1:0] a_i,
  input  logic [WORD_SIZE_P-1:0] b_i,
  input  logic [TAG_W-1:0]       dest_i,
  input  logic                   rem_sel_i,
  output logic                   idle_o,
  output logic                   done_o,
  output logic [WORD_SIZE_P-1:0] quotient_o,
  output logic [WORD_SIZE_P-1:0] remainder_o,
  output logic [TAG_W-1:0]       dest_o,
  output logic                   rem_sel_o
);

  localparam int unsigned CNT_W = $clog2(WORD_SIZE_P);

  divfsm_e                state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [WORD_SIZE_P-1:0] rem_q, quot_q, divisor_q;
  logic [TAG_W-1:0]       dest_q;
  logic                   rem_sel_q;
  logic [WORD_SIZE_P:0]   shifted, diff;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = BUSY;
      BUSY:    if (cnt_q == CNT_W'(WORD_SIZE_P - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Partial remainder shifted left with the next dividend bit pulled in from
  // the top of the quotient register; a borrow in diff means "restore".
  assign shifted = {rem_q, quot_q[WORD_SIZE_P-1]};
  assign diff    = shifted - {1'b0, divisor_q};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      dest_q    <= '0;
      rem_sel_q <= 1'b0;
    end else if (state_q == IDLE && start_i) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= a_i;
      divisor_q <= b_i;
      dest_q    <= dest_i;
      rem_sel_q <= rem_sel_i;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 1'b1;
      if (!diff[WORD_SIZE_P]) begin
        rem_q  <= diff[WORD_SIZE_P-1:0];
        quot_q <= {quot_q[WORD_SIZE_P-2:0], 1'b1};
      end else begin
        rem_q  <= shifted[WORD_SIZE_P-1:0];
        quot_q <= {quot_q[WORD_SIZE_P-2:0], 1'b0};
      end
    end
  end

  assign idle_o      = (state_q == IDLE);
  assign done_o      = (state_q == DONE);
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign dest_o      = dest_q;
  assign rem_sel_o   = rem_sel_q;

endmodule

// File: rtl/muldiv_fu.sv
// muldiv_fu: multiply/divide functional unit with its own CDB slot.
//   clk_i, reset_i (async, active-low)
//   instruction_i / valid_i  issued op; taken when valid_i & ready_o & ~flush_i
//   ready_o                  unit can accept an op this cycle
//   flush_i                  kill all in-flight work
//   cdb_o                    registered {valid, dest, result} broadcast
// Optional: `define MULDIV_DIV_EN to build the iterative divider (DIV/REM,
// WORD_SIZE_P+1 cycle latency). Without it DIV/REM return 0 with MUL timing
// and ready_o is tied high.
module muldiv_fu
  import Purple_Jade_pkg::*;
#(
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned FU_ID      = FU_MULDIV
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  issued_instruction_t instruction_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                flush_i,
  output CDB_t                cdb_o
);

  if (MUL_STAGES < 1) begin : g_bad_stages
    $error("muldiv_fu %0d: MUL_STAGES must be at least 1", FU_ID);
  end

  logic                   accept, is_divrem, mul_in_v;
  logic [WORD_SIZE_P-1:0] op_a, op_b, mul_res;
  CDB_t                   cdb_d;

  logic                   mul_v    [MUL_STAGES];
  logic [TAG_W-1:0]       mul_dest [MUL_STAGES];
  logic [WORD_SIZE_P-1:0] mul_data [MUL_STAGES];

  assign op_a   = instruction_i.source_1_data;
  assign op_b   = instruction_i.source2_imm_data;
  assign accept = valid_i & ready_o & ~flush_i;

  always_comb begin
    mul_res   = '0;
    is_divrem = 1'b0;
    if (instruction_i.opcode == OP_MUL) mul_res = op_a * op_b;
`ifdef MULDIV_DIV_EN
    is_divrem = (instruction_i.opcode == OP_DIV) || (instruction_i.opcode == OP_REM);
`endif
  end

  assign mul_in_v = accept & ~is_divrem;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i || flush_i) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        mul_v[i]    <= 1'b0;
        mul_dest[i] <= '0;
        mul_data[i] <= '0;
      end
    end else begin
      mul_v[0]    <= mul_in_v;
      mul_dest[0] <= mul_in_v ? instruction_i.dest_id : '0;
      mul_data[0] <= mul_in_v ? mul_res : '0;
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        mul_v[i]    <= mul_v[i-1];
        mul_dest[i] <= mul_dest[i-1];
        mul_data[i] <= mul_data[i-1];
      end
    end
  end

`ifdef MULDIV_DIV_EN
  logic                   div_idle, div_done, div_rem_sel;
  logic [WORD_SIZE_P-1:0] div_quot, div_rem;
  logic [TAG_W-1:0]       div_dest;

  iterative_divider u_div (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (accept & is_divrem),
    .flush_i     (flush_i),
    .a_i         (op_a),
    .b_i         (op_b),
    .dest_i      (instruction_i.dest_id),
    .rem_sel_i   (instruction_i.opcode == OP_REM),
    .idle_o      (div_idle),
    .done_o      (div_done),
    .quotient_o  (div_quot),
    .remainder_o (div_rem),
    .dest_o      (div_dest),
    .rem_sel_o   (div_rem_sel)
  );

  assign ready_o = div_idle;

  always_comb begin
    cdb_d = '0;
    if (div_done) begin
      cdb_d.valid  = 1'b1;
      cdb_d.dest   = CDB_DEST_W'(div_dest);
      cdb_d.result = div_rem_sel ? div_rem : div_quot;
    end else if (mul_v[MUL_STAGES-1]) begin
      cdb_d.valid  = 1'b1;
      cdb_d.dest   = CDB_DEST_W'(mul_dest[MUL_STAGES-1]);
      cdb_d.result = mul_data[MUL_STAGES-1];
    end
  end

  a_no_cdb_collision: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(div_done && mul_v[MUL_STAGES-1]))
    else $error("muldiv_fu %0d: divider and multiplier results collide on CDB", FU_ID);
`else
  assign ready_o = 1'b1;

  always_comb begin
    cdb_d = '0;
    if (mul_v[MUL_STAGES-1]) begin
      cdb_d.valid  = 1'b1;
      cdb_d.dest   = CDB_DEST_W'(mul_dest[MUL_STAGES-1]);
      cdb_d.result = mul_data[MUL_STAGES-1];
    end
  end
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)     cdb_o <= '0;
    else if (flush_i) cdb_o <= '0;
    else              cdb_o <= cdb_d;
  end

endmodule

// File: tb/tb_muldiv_fu.sv
module tb_muldiv_fu;
  import Purple_Jade_pkg::*;

  localparam int unsigned MS      = 2;
  localparam int unsigned DIV_LAT = WORD_SIZE_P + 1;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic                clk_i = 1'b0;
  logic                reset_i;
  issued_instruction_t instruction_i;
  logic                valid_i, flush_i, ready_o;
  CDB_t                cdb_o;

  always #5 clk_i = ~clk_i;

  muldiv_fu #(.MUL_STAGES(MS), .FU_ID(FU_MULDIV)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .instruction_i (instruction_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .flush_i       (flush_i),
    .cdb_o         (cdb_o)
  );

  typedef struct {
    int unsigned            cyc;
    logic [CDB_DEST_W-1:0]  dest;
    logic [WORD_SIZE_P-1:0] result;
    string                  name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_pass = 0, n_total = 0;
  int unsigned valid_seen = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every CDB broadcast must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (reset_i === 1'b1 && cdb_o.valid === 1'b1) begin
      valid_seen++;
      if (sb.size() == 0) begin
        check("unexpected_cdb_valid", 32'(cdb_o.valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_cycle"},  cyc,                  e.cyc);
        check({e.name, "_dest"},   32'(cdb_o.dest),      32'(e.dest));
        check({e.name, "_result"}, 32'(cdb_o.result),    32'(e.result));
      end
    end
  end

  task automatic push(input exp_t e);
    int unsigned idx;
    idx = sb.size();
    for (int unsigned i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > e.cyc) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic issue(input string name, input logic [OPCODE_W-1:0] op,
                       input logic [WORD_SIZE_P-1:0] a, input logic [WORD_SIZE_P-1:0] b,
                       input logic [TAG_W-1:0] dest, input logic [WORD_SIZE_P-1:0] res);
    exp_t e;
    bit   dr;
    dr = (op == OP_DIV) || (op == OP_REM);
    instruction_i = '{opcode: op, dest_id: dest, source_1_data: a, source2_imm_data: b};
    valid_i  = 1'b1;
    e.cyc    = cyc + 1 + ((DIV_EN && dr) ? DIV_LAT : MS);
    e.dest   = CDB_DEST_W'(dest);
    e.result = (!DIV_EN && dr) ? '0 : res;
    e.name   = name;
    push(e);
    @(negedge clk_i);
    valid_i       = 1'b0;
    instruction_i = '0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk_i);
    @(negedge clk_i);
    check({name, "_drained"}, sb.size(), 32'd0);
    check({name, "_ready_after"}, 32'(ready_o), 32'd1);
  endtask

  task automatic flush_cycle();
    flush_i = 1'b1;
    sb.delete();
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned low_cnt, seen0;
    reset_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0; instruction_i = '0;
    #1;
    check("reset_cdb",   32'(cdb_o),   32'd0);
    check("reset_ready", 32'(ready_o), 32'd1);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);

    // Single MUL, ready must stay high.
    issue("mul_3x5", OP_MUL, 16'd3, 16'd5, 4'd7, 16'h000F);
    check("mul_ready_stays", 32'(ready_o), 32'd1);
    drain("mul_3x5");

    // Back-to-back MULs, results on consecutive cycles.
    issue("mul_1234x10", OP_MUL, 16'h1234, 16'h0010, 4'd1, 16'h2340);
    issue("mul_ffffxffff", OP_MUL, 16'hFFFF, 16'hFFFF, 4'd2, 16'h0001);
    drain("mul_b2b");

    // Unknown opcode: zero result, MUL timing.
    issue("op_other", 4'h3, 16'd5, 16'd6, 4'd4, 16'h0000);
    drain("op_other");

    // DIV 100/7 with ready low window measured.
    issue("div_100_7", OP_DIV, 16'd100, 16'd7, 4'd3, 16'd14);
    low_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (ready_o === 1'b0) low_cnt++;
      @(negedge clk_i);
    end
    check("div_ready_low_cycles", low_cnt, DIV_EN ? DIV_LAT : 32'd0);
    drain("div_100_7");

    issue("rem_100_7", OP_REM, 16'd100, 16'd7, 4'd6, 16'd2);
    drain("rem_100_7");
    issue("div_by_zero", OP_DIV, 16'h1234, 16'h0000, 4'd5, 16'hFFFF);
    drain("div_by_zero");
    issue("rem_by_zero", OP_REM, 16'h1234, 16'h0000, 4'd5, 16'h1234);
    drain("rem_by_zero");
    issue("div_ffff_3", OP_DIV, 16'hFFFF, 16'h0003, 4'hF, 16'h5555);
    drain("div_ffff_3");
    issue("rem_fffe_10", OP_REM, 16'hFFFE, 16'h0010, 4'hE, 16'h000E);
    drain("rem_fffe_10");

    // MUL then DIV on the next cycle: separate CDB cycles.
    issue("mix_mul", OP_MUL, 16'd7, 16'd9, 4'd8, 16'd63);
    issue("mix_div", OP_DIV, 16'd1000, 16'd10, 4'd9, 16'd100);
    drain("mix");

    // Flush with a MUL in flight and a DIV just started.
    issue("fl_mul", OP_MUL, 16'd2, 16'd2, 4'd10, 16'd4);
    issue("fl_div", OP_DIV, 16'd50, 16'd5, 4'd11, 16'd10);
    seen0 = valid_seen;
    flush_cycle();
    check("flush1_ready_next", 32'(ready_o), 32'd1);
    repeat (25) @(negedge clk_i);
    check("flush1_no_cdb", valid_seen - seen0, 32'd0);

    // Flush in cycle 5 of a DIV.
    issue("fl5_div", OP_DIV, 16'd99, 16'd9, 4'd12, 16'd11);
    repeat (3) @(negedge clk_i);
    seen0 = valid_seen;
    flush_cycle();
    check("flush5_ready_next", 32'(ready_o), 32'd1);
    repeat (25) @(negedge clk_i);
    check("flush5_no_cdb", valid_seen - seen0, 32'd0);

    // An op presented together with flush is dropped.
    seen0 = valid_seen;
    instruction_i = '{opcode: OP_MUL, dest_id: 4'd13, source_1_data: 16'd4, source2_imm_data: 16'd4};
    valid_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0; instruction_i = '0;
    repeat (5) @(negedge clk_i);
    check("flush_drop_op", valid_seen - seen0, 32'd0);

    // Asynchronous reset in the middle of a DIV.
    issue("rst_div", OP_DIV, 16'd200, 16'd3, 4'd14, 16'd66);
    repeat (4) @(negedge clk_i);
    #2 reset_i = 1'b0;
    #1;
    check("async_rst_cdb",   32'(cdb_o),   32'd0);
    check("async_rst_ready", 32'(ready_o), 32'd1);
    sb.delete();
    @(negedge clk_i);
    reset_i = 1'b1;
    seen0 = valid_seen;
    repeat (25) @(negedge clk_i);
    check("async_rst_no_cdb", valid_seen - seen0, 32'd0);

    // Normal operation after reset.
    issue("post_rst_mul", OP_MUL, 16'h0100, 16'h0003, 4'd2, 16'h0300);
    drain("post_rst_mul");

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
